// File: rtl/result_fifo_pkg.sv
// Shared constants and helpers for the result buffer stage.
// Holds the default word width / depth and the pointer index width derivation.
// Pure compile-time content: no logic, no latency, no flow control.
package result_fifo_pkg;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 4;

  // Index bits needed to address DEPTH entries; the pointers carry one extra wrap bit.
  function automatic int ptr_idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Purpose: first-word-fall-through buffer for datapath results, power-of-two depth.
// Latency: in_valid to out_valid is 1 cycle; no combinational bypass of storage.
// Backpressure: none upstream. A word arriving while full with no pop is dropped, setting sticky overflow.
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   in_valid, in_data     upstream result, sampled every cycle
//   out_valid, out_ready  consumer handshake, out_data is the head entry
//   count, full, empty    occupancy status
//   overflow, clr_ovf     sticky drop flag and its synchronous clear
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = ptr_idx_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Occupancy comes straight from the pointer difference; the wrap bit
  // distinguishes full from empty when the index bits match.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign out_valid = !empty;
  assign out_data  = storage[rd_ptr[AW-1:0]];

  assign pop  = out_valid & out_ready;
  // A same-cycle pop frees the head slot, so a full buffer can still accept.
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (push) begin
        storage[wr_ptr[AW-1:0]] <= in_data;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set so no loss goes unreported.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
